// File: rtl/timers_pkg.sv
// rtl/timers_pkg.sv - shared segment encodings and display-off constants for the timers block
package timers_pkg;

  localparam logic [3:0] ANODE_OFF   = 4'hF;
  localparam logic [7:0] CATHODE_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}; the decimal point is added by the caller.
  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;

  function automatic logic [6:0] seg7(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_mux.sv
// rtl/seven_seg_mux.sv - scan prescaler, digit select and registered anode/cathode drive
module seven_seg_mux
  import timers_pkg::*;
#(
  parameter int SCAN_DIV = 100_000
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic [3:0] ANODE,
  output logic [7:0] CATHODE
);

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0] scan_cnt;
  logic [1:0]    sel;
  logic          scan_tick;
  logic [3:0]    digit;

  assign scan_tick = (scan_cnt == SCAN_LAST);

  always_comb begin
    digit = d0;
    case (sel)
      2'd0: digit = d0;
      2'd1: digit = d1;
      2'd2: digit = d2;
      2'd3: digit = d3;
      default: digit = d0;
    endcase
  end

  // Outputs sample the current sel/digits, so they trail any change by one clock.
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      scan_cnt <= '0;
      sel      <= 2'd0;
      ANODE    <= ANODE_OFF;
      CATHODE  <= CATHODE_OFF;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      if (scan_tick) sel <= sel + 2'd1;
      ANODE   <= ~(4'b0001 << sel);
      CATHODE <= {1'b1, seg7(digit)};
    end
  end

endmodule

// File: rtl/pb_timers_top.sv
// rtl/pb_timers_top.sv - count prescaler and 4-digit BCD up-counter driving the scanned display
module pb_timers_top
  import timers_pkg::*;
#(
  parameter int SCAN_DIV  = 100_000,
  parameter int COUNT_DIV = 10_000_000
) (
  input  logic       CLK_IN,
  input  logic       RESET_IN,
  output logic [3:0] ANODE,
  output logic [7:0] CATHODE
);

  localparam int CW = (COUNT_DIV > 2) ? $clog2(COUNT_DIV) : 1;
  localparam logic [CW-1:0] COUNT_LAST = CW'(COUNT_DIV - 1);

  logic [CW-1:0]   count_cnt;
  logic            count_tick;
  logic [3:0][3:0] d;
  logic [3:0][3:0] d_next;

  assign count_tick = (count_cnt == COUNT_LAST);

  // Ripple carry across digits; 9999 rolls to 0000 with no overflow indication.
  always_comb begin
    logic carry;
    carry  = count_tick;
    d_next = d;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (d[i] == 4'd9) begin
          d_next[i] = 4'd0;
        end else begin
          d_next[i] = d[i] + 4'd1;
          carry     = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      count_cnt <= '0;
      d         <= '0;
    end else begin
      count_cnt <= count_tick ? '0 : count_cnt + 1'b1;
      d         <= d_next;
    end
  end

  seven_seg_mux #(
    .SCAN_DIV (SCAN_DIV)
  ) u_mux (
    .CLK_IN   (CLK_IN),
    .RESET_IN (RESET_IN),
    .d3       (d[3]),
    .d2       (d[2]),
    .d1       (d[1]),
    .d0       (d[0]),
    .ANODE    (ANODE),
    .CATHODE  (CATHODE)
  );

endmodule

// File: tb/tb_pb_timers_top.sv
// tb/tb_pb_timers_top.sv - scoreboard bench for pb_timers_top against a cycle-count reference model
module tb_pb_timers_top;

  localparam int S = 4;
  localparam int C = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] anode;
  logic [7:0] cathode;

  pb_timers_top #(
    .SCAN_DIV  (S),
    .COUNT_DIV (C)
  ) dut (
    .CLK_IN   (clk),
    .RESET_IN (rst_n),
    .ANODE    (anode),
    .CATHODE  (cathode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [7:0] ca;
  } exp_t;

  exp_t       sb[$];
  int         k = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] seg_tab [10];

  initial begin
    seg_tab[0] = 8'hC0; seg_tab[1] = 8'hF9; seg_tab[2] = 8'hA4; seg_tab[3] = 8'hB0;
    seg_tab[4] = 8'h99; seg_tab[5] = 8'h92; seg_tab[6] = 8'h82; seg_tab[7] = 8'hF8;
    seg_tab[8] = 8'h80; seg_tab[9] = 8'h90;
  end

  // Display after the k-th clock edge since reset release: the registers show the
  // digit select and count value as they stood just before that edge.
  function automatic exp_t model(input int kk);
    exp_t e;
    int   sel;
    int   val;
    int   dig;
    sel = ((kk - 1) / S) % 4;
    val = ((kk - 1) / C) % 10000;
    dig = val;
    for (int i = 0; i < sel; i++) dig = dig / 10;
    dig = dig % 10;
    e.k       = kk;
    e.an      = 4'hF;
    e.an[sel] = 1'b0;
    e.ca      = seg_tab[dig];
    return e;
  endfunction

  always @(negedge rst_n) k = 0;

  always @(posedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      k = k + 1;
      e = model(k);
    end else begin
      e.k  = 0;
      e.an = 4'hF;
      e.ca = 8'hFF;
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      tests++;
      if (anode !== e.an || cathode !== e.ca) begin
        fails++;
        $display("FAIL display k=%0d got anode=%b cathode=%h expected anode=%b cathode=%h",
                 e.k, anode, cathode, e.an, e.ca);
      end
    end
  end

  task automatic check_off(input string name);
    tests++;
    if (anode !== 4'hF || cathode !== 8'hFF) begin
      fails++;
      $display("FAIL %s got anode=%b cathode=%h expected anode=1111 cathode=ff",
               name, anode, cathode);
    end
  endtask

  // Reset edges land between the negedge sample and the next posedge, never on a clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    check_off("reset_async");
    repeat ($urandom_range(1, 3)) @(negedge clk);
    #($urandom_range(1, 3));
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    #1000;
    check_off("reset_hold");
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(20, 300)) @(posedge clk);
      pulse_reset();
    end

    // Stop with the count at 0042, then confirm the restart from 0000.
    repeat (42 * C + 2) @(posedge clk);
    pulse_reset();

    // Long enough to pass 9999 -> 0000.
    repeat (10000 * C + 50) @(posedge clk);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
